// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Issue-side sequencer for the datapath ALU. It accepts one request over a
//   valid/ready handshake, holds the ALU select/operands for the op's
//   multi-cycle latency, captures the ALU's {HI,LO} result, and returns it to
//   the register file as one LO beat, followed by a HI beat for MUL and DIV.
//   Illegal opcodes and divide-by-zero produce a one-cycle error pulse and
//   are never issued to the ALU.
// Ports
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready/req_op/a/b/y  request handshake and payload
//   alu_select/alu_a/alu_b/alu_y      drive to ALU (select 0000 = hold)
//   alu_c                            ALU registered result {HI,LO}
//   wb_valid/wb_ready/wb_sel/wb_data  write-back beats (sel 1 = HI)
//   err_valid/err_code               error pulse (01 illegal, 10 div by 0)
//   busy                             sequencer not idle
module alu_op_sequencer #(
  parameter int DW      = 32,
  parameter int MUL_CYC = 2,
  parameter int DIV_CYC = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_op,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  input  logic [DW-1:0] req_y,
  output logic [3:0]    alu_select,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [DW-1:0] alu_y,
  input  logic [2*DW-1:0] alu_c,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic          wb_sel,
  output logic [DW-1:0] wb_data,
  output logic          err_valid,
  output logic [1:0]    err_code,
  output logic          busy
);

  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0101;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_WB_LO   = 3'd3;
  localparam logic [2:0] S_WB_HI   = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  localparam int MAXC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  // Counter holds N-1, so $clog2(MAXC) bits cover the largest hold.
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef struct packed {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] y;
  } req_t;

  logic [2:0]      state, state_n;
  logic [CW-1:0]   cnt;
  logic [2*DW-1:0] res_q;
  logic [1:0]      err_q;
  logic            rdy_q;
  req_t            req_q;
  logic            accept, legal, div0, two_beat;

  always_comb begin
    legal = 1'b1;
    case (req_op)
      4'b0000, 4'b0100, 4'b1001, 4'b1011: legal = 1'b0;
      default:                            legal = 1'b1;
    endcase
  end

  assign accept   = (state == S_IDLE) && req_valid && rdy_q;
  assign div0     = (req_op == OP_DIV) && (req_b == '0);
  assign two_beat = (req_q.op == OP_MUL) || (req_q.op == OP_DIV);

  function automatic logic [CW-1:0] hold_cnt(input logic [3:0] op);
    case (op)
      OP_MUL:  hold_cnt = CW'(MUL_CYC - 1);
      OP_DIV:  hold_cnt = CW'(DIV_CYC - 1);
      default: hold_cnt = '0;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (accept) state_n = (!legal || div0) ? S_ERR : S_ISSUE;
      S_ISSUE:   if (cnt == '0) state_n = S_CAPTURE;
      S_CAPTURE: state_n = S_WB_LO;
      S_WB_LO:   if (wb_ready) state_n = two_beat ? S_WB_HI : S_IDLE;
      S_WB_HI:   if (wb_ready) state_n = S_IDLE;
      S_ERR:     state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rdy_q <= 1'b0;
      cnt   <= '0;
      res_q <= '0;
      err_q <= 2'b00;
      req_q <= '0;
    end else begin
      state <= state_n;
      // Ready is registered: it lands on the edge that enters IDLE, which
      // also makes it rise on the first edge out of reset.
      rdy_q <= (state_n == S_IDLE);
      if (accept) begin
        req_q <= '{op: req_op, a: req_a, b: req_b, y: req_y};
        err_q <= legal ? 2'b10 : 2'b01;
        cnt   <= hold_cnt(req_op);
      end
      if (state == S_ISSUE && cnt != '0) cnt <= cnt - CW'(1);
      if (state == S_CAPTURE) res_q <= alu_c;
    end
  end

  // Outputs decode from registered state so reset clears them immediately.
  assign req_ready  = rdy_q;
  assign alu_select = (state == S_ISSUE) ? req_q.op : 4'b0000;
  assign alu_a      = req_q.a;
  assign alu_b      = req_q.b;
  assign alu_y      = req_q.y;
  assign wb_valid   = (state == S_WB_LO) || (state == S_WB_HI);
  assign wb_sel     = (state == S_WB_HI);
  assign wb_data    = (state == S_WB_LO) ? res_q[DW-1:0] :
                      (state == S_WB_HI) ? res_q[2*DW-1:DW] : '0;
  assign err_valid  = (state == S_ERR);
  assign err_code   = (state == S_ERR) ? err_q : 2'b00;
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [3:0]    req_op;
  logic [DW-1:0] req_a, req_b, req_y;
  logic [3:0]    alu_select;
  logic [DW-1:0] alu_a, alu_b, alu_y;
  logic [2*DW-1:0] alu_c;
  logic          wb_valid, wb_ready, wb_sel;
  logic [DW-1:0] wb_data;
  logic          err_valid, busy;
  logic [1:0]    err_code;

  int n_cmp = 0;
  int n_mis = 0;
  int beats = 0;
  int accepts = 0;
  int issue_cyc = 0;
  logic [DW:0] exp_q[$];

  alu_op_sequencer #(.DW(DW), .MUL_CYC(2), .DIV_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_y(req_y),
    .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .alu_c(alu_c),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_sel(wb_sel), .wb_data(wb_data),
    .err_valid(err_valid), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the datapath ALU: samples whenever select != 0.
  function automatic logic [63:0] alu_f(input logic [3:0] op,
                                        input logic [31:0] a, b);
    case (op)
      4'b0001: alu_f = {32'd0, a + b};
      4'b0010: alu_f = {32'd0, a - b};
      4'b0011: alu_f = {32'd0, a} * {32'd0, b};
      4'b0101: alu_f = (b == 0) ? 64'd0 : {a % b, a / b};
      4'b0110: alu_f = {32'd0, a & b};
      4'b0111: alu_f = {32'd0, a | b};
      4'b1000: alu_f = {32'd0, -a};
      4'b1010: alu_f = {32'd0, ~a};
      4'b1100: alu_f = {32'd0, a << b[4:0]};
      4'b1101: alu_f = {32'd0, a >> b[4:0]};
      default: alu_f = 64'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) alu_c <= '0;
    else if (alu_select != 4'd0) alu_c <= alu_f(alu_select, alu_a, alu_b);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor plus write-back stability and accept/issue counting.
  logic          prev_stall = 1'b0;
  logic          prev_sel;
  logic [DW-1:0] prev_data;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("wb_hold_valid", wb_valid, 1);
        check("wb_hold_sel", wb_sel, prev_sel);
        check("wb_hold_data", wb_data, prev_data);
      end
      if (alu_select != 4'd0) issue_cyc++;
      if (req_valid && req_ready) accepts++;
      if (wb_valid && wb_ready) begin
        beats++;
        if (exp_q.size() == 0) check("wb_unexpected", {wb_sel, wb_data}, 0);
        else check("wb_beat", {31'd0, wb_sel, wb_data}, {31'd0, exp_q.pop_front()});
      end
    end
    prev_stall = rst_n && wb_valid && !wb_ready;
    prev_sel   = wb_sel;
    prev_data  = wb_data;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 60) begin step(); n++; end
    check(tag, req_ready, 1);
  endtask

  // Returns one time unit after the accept edge (state is then ISSUE/ERR).
  task automatic send(input logic [3:0] op, input logic [31:0] a, b);
    wait_ready("ready_before_send");
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_y = 32'h5a5a;
    step();
    req_valid = 1'b0;
  endtask

  task automatic push(input logic sel, input logic [31:0] d);
    exp_q.push_back({sel, d});
  endtask

  initial begin
    int n, base;
    logic [31:0] oa, ob;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    req_y = '0; wb_ready = 1'b0;
    #3;
    check("rst_ready", req_ready, 0);
    check("rst_sel", alu_select, 0);
    check("rst_a", alu_a, 0);
    check("rst_wb", {wb_valid, wb_sel, wb_data}, 0);
    check("rst_err", {err_valid, err_code}, 0);
    check("rst_busy", busy, 0);
    #9 rst_n = 1'b1;
    step();
    check("ready_after_rst", req_ready, 1);

    // ADD 5+7: one ISSUE cycle, LO beat three cycles after accept.
    wb_ready = 1'b1;
    send(4'b0001, 5, 7); push(0, 12);
    check("add_issue_sel", alu_select, 4'b0001);
    check("add_ready_drop", req_ready, 0);
    check("add_busy", busy, 1);
    step(); check("add_capture_sel", alu_select, 0);
    check("add_no_wb_early", wb_valid, 0);
    step(); check("add_wb_valid", wb_valid, 1);
    check("add_wb_data", wb_data, 12);
    check("add_wb_sel", wb_sel, 0);
    step(); check("add_wb_done", wb_valid, 0);
    check("add_ready_back", req_ready, 1);

    // MUL 0x10000*0x10000: two ISSUE cycles, LO=0 then HI=1.
    send(4'b0011, 32'h0001_0000, 32'h0001_0000); push(0, 0); push(1, 1);
    check("mul_issue0", alu_select, 4'b0011);
    step(); check("mul_issue1", alu_select, 4'b0011);
    step(); check("mul_capture", alu_select, 0);
    step(); check("mul_lo", {wb_valid, wb_sel, wb_data}, {2'b10, 32'd0});
    step(); check("mul_hi", {wb_valid, wb_sel, wb_data}, {2'b11, 32'd1});
    step(); check("mul_ready_back", req_ready, 1);

    // DIV 17/5 with write-back stalled for 3 cycles.
    wb_ready = 1'b0;
    send(4'b0101, 17, 5); push(0, 3); push(1, 2);
    n = 0;
    while (!wb_valid && n < 20) begin
      check("div_busy_issue", busy, 1);
      step(); n++;
    end
    check("div_wb_arrives", wb_valid, 1);
    for (int i = 0; i < 3; i++) begin
      check("div_stall_data", wb_data, 3);
      check("div_stall_busy", busy, 1);
      step();
    end
    wb_ready = 1'b1;
    step(); check("div_hi", {wb_sel, wb_data}, {1'b1, 32'd2});
    wait_ready("div_ready_back");

    // Errors: divide by zero, then illegal opcode. No issue, no write-back.
    base = issue_cyc; n = beats;
    send(4'b0101, 9, 0);
    check("div0_err", {err_valid, err_code}, 3'b110);
    check("div0_sel", alu_select, 0);
    step(); check("div0_pulse_end", err_valid, 0);
    check("div0_ready", req_ready, 1);
    send(4'b0100, 1, 2);
    check("ill_err", {err_valid, err_code}, 3'b101);
    step(); check("ill_pulse_end", err_valid, 0);
    step();
    check("err_no_issue", issue_cyc - base, 0);
    check("err_no_wb", beats - n, 0);

    // Reset during MUL ISSUE aborts everything at once.
    send(4'b0011, 3, 4);
    check("mul_in_issue", alu_select, 4'b0011);
    rst_n = 1'b0; #1;
    check("abort_sel", alu_select, 0);
    check("abort_outs", {req_ready, wb_valid, err_valid, busy}, 0);
    check("abort_a", alu_a, 0);
    @(negedge clk); rst_n = 1'b1;
    exp_q.delete();
    step(); check("abort_ready", req_ready, 1);
    send(4'b0001, 1, 1); push(0, 2);
    wait_ready("post_abort_ready");
    check("post_abort_drain", exp_q.size(), 0);

    // req_valid held high across three ORs: one accept per IDLE visit.
    base = accepts; n = beats;
    req_valid = 1'b1; req_op = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      wait_ready("or_ready");
      oa = 32'h100 << i; ob = 32'h3 + i;
      req_a = oa; req_b = ob;
      push(0, oa | ob);
      step();
    end
    req_valid = 1'b0;
    wait_ready("or_ready_end");
    check("or_accepts", accepts - base, 3);
    check("or_beats", beats - n, 3);
    check("final_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue-side counterpart of the datapath ALU: accepts one operation request over a valid/ready handshake.
- Drives the ALU select and operand inputs for the required number of cycles, then captures the ALU's 64-bit {HI,LO} result.
- Returns the result to the register file over a valid/ready write-back port: LO always, HI as well for MUL and DIV.
- Sits between the control unit and the ALU; the only thing that drives the ALU select.

Parameters:
- DW, 32, operand and half-result width.
- MUL_CYC, 2, cycles select/operands are held for MUL (>=1).
- DIV_CYC, 4, cycles select/operands are held for DIV (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  4  ALU opcode
- req_a  in  DW  operand A
- req_b  in  DW  operand B
- req_y  in  DW  operand Y
- alu_select  out  4  opcode to ALU; 4'b0000 = hold
- alu_a  out  DW  operand A to ALU
- alu_b  out  DW  operand B to ALU
- alu_y  out  DW  operand Y to ALU
- alu_c  in  2*DW  ALU result {HI,LO}, registered inside the ALU
- wb_valid  out  1  write-back beat valid
- wb_ready  in  1  register file accepts beat
- wb_sel  out  1  0 = LO/destination beat, 1 = HI beat
- wb_data  out  DW  write-back data
- err_valid  out  1  one-cycle error pulse
- err_code  out  2  01 = illegal opcode, 10 = divide by zero
- busy  out  1  state != IDLE

Behaviour:
- Legal opcodes:
  - 0001 ADD, 0010 SUB, 0011 MUL, 0101 DIV, 0110 AND, 0111 OR
  - 1000 NEG, 1010 NOT, 1100 SHL, 1101 SHR, 1110 ROL, 1111 ROR
  - 0000, 0100, 1001, 1011 are illegal.
- Reset (rst_n low, async): state IDLE, all outputs 0 (req_ready 0, alu_select 0000, alu_a/b/y 0, wb_* 0, err_* 0), hold counter 0, result register 0.
- req_ready is a registered flag: it goes 1 on the first clk edge with rst_n high, and is 1 only in IDLE.
- Accept occurs on an edge with req_valid & req_ready:
  - latch op, a, b, y;
  - req_ready drops the same edge.
- States:
  - IDLE: wait for accept. An illegal op goes to ERR. DIV with req_b==0 goes to ERR. Everything else goes to ISSUE with counter = N-1, where N = MUL_CYC for MUL, DIV_CYC for DIV, 1 otherwise.
  - ISSUE: alu_select = latched op, alu_a/b/y = latched operands. Decrement the counter each cycle; leave to CAPTURE when it is 0. The ALU samples on every ISSUE edge.
  - CAPTURE: alu_select = 0000, operands still held; result register <= alu_c. Go to WB_LO.
  - WB_LO: wb_valid=1, wb_sel=0, wb_data=result[DW-1:0]. Hold until wb_ready. On handshake, go to WB_HI if op is MUL or DIV, else to IDLE.
  - WB_HI: wb_valid=1, wb_sel=1, wb_data=result[2*DW-1:DW]. Hold until wb_ready, then go to IDLE.
  - ERR: err_valid=1 for exactly this cycle with err_code. No ALU issue, no write-back. Go to IDLE.
- alu_select is 0000 in every state except ISSUE, so the ALU keeps its held value.
- wb_data and wb_sel are stable while wb_valid=1 && !wb_ready.
- Latency for a simple op with wb_ready tied 1:
  - accept edge E0;
  - ISSUE cycle E0–E1;
  - CAPTURE E1–E2;
  - WB_LO E2–E3, handshake at E3;
  - req_ready=1 from E3.
  - One op every 4 cycles. MUL adds MUL_CYC-1 cycles plus 1 HI beat.
- wb_ready asserted outside WB_LO/WB_HI is ignored. req_valid outside IDLE is ignored; no queueing.
- Reset mid-operation aborts immediately: no partial write-back, and alu_select returns to 0000 asynchronously.

Test Plan:
- ADD a=5, b=7, wb_ready=1 -> alu_select=0001 for 1 cycle; one beat wb_sel=0, wb_data=12 three cycles after accept; req_ready back at the 4th edge.
- MUL a=0x0001_0000, b=0x0001_0000, MUL_CYC=2 -> alu_select=0011 for 2 cycles; beats LO=0x0000_0000 then HI=0x0000_0001.
- DIV a=17, b=5, DIV_CYC=4, wb_ready low 3 cycles then high -> wb_valid held with stable LO=3 for 3 cycles, then HI=2; busy high throughout.
- DIV b=0, then op=0100 -> err_valid one cycle with err_code=10, then err_code=01; alu_select never leaves 0000; no wb_valid.
- rst_n pulled low during ISSUE of MUL -> all outputs 0 immediately; after release req_ready=1 one edge later; the next ADD 1+1 writes back 2.
- req_valid held high continuously across 3 ORs -> exactly 3 accepts, one per IDLE visit, and 3 LO beats in order.
